// File: rtl/out_value_uart_tx.sv
// -----------------------------------------------------------------------------
// out_value_uart_tx
//
// Watches the CPU's Out_value result bus, captures every change into a small
// word FIFO and shifts each queued word out as DATA_W/8 back-to-back UART
// frames (LSB first, byte 0 = Out_value[7:0] first). Frames are 8N1 by default.
//
// Optional feature (macro OUT_VALUE_TX_PARITY_EN):
//   when defined, an even-parity bit is inserted between the data bits and the
//   stop bit of every frame (8E1, 11 bits per frame).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   Out_value  - CPU result bus, sampled every rising edge
//   capture_en - 1 = change detection active, 0 = bus ignored, prev frozen
//   tx         - UART serial line, idle high
//   busy       - high while a word is being shifted or the FIFO holds words
//   overflow   - sticky, set when a change was dropped because the FIFO was full
//   fifo_count - current FIFO occupancy (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module out_value_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             Out_value,
  input  logic                          capture_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BYTES  = DATA_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CLK_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef OUT_VALUE_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Capture / FIFO state
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  // Serializer state
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic              tx_q, tx_d;
`ifdef OUT_VALUE_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic bit_done;

  // Change detection and FIFO bookkeeping. A pop on the same edge frees a
  // slot, so a push into a full FIFO is still accepted in that case.
  always_comb begin
    push_req   = capture_en && (Out_value != prev_q);
    pop        = (state_q == IDLE) && (count_q != '0);
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    push       = push_req && (!full || pop);

    prev_d     = push_req ? Out_value : prev_q;
    overflow_d = overflow_q | (push_req & full & ~pop);

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = Out_value;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer. The word is shifted right one bit per data bit, so after
  // the eighth bit the next byte already sits in the low bits for its frame.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    clk_cnt_d  = clk_cnt_q;
`ifdef OUT_VALUE_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    bit_done   = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = START;
        end
      end

      START: begin
`ifdef OUT_VALUE_TX_PARITY_EN
        parity_d = ^shift_q[7:0];
`endif
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end

      DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef OUT_VALUE_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end

`ifdef OUT_VALUE_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (byte_idx_q != BYTE_W'(BYTES - 1)) begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
      end
    endcase

    // tx is registered from the next state so the pin never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef OUT_VALUE_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      clk_cnt_q  <= '0;
      tx_q       <= 1'b1;
`ifdef OUT_VALUE_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      prev_q     <= prev_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      clk_cnt_q  <= clk_cnt_d;
      tx_q       <= tx_d;
`ifdef OUT_VALUE_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_out_value_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_out_value_uart_tx
//
// Directed bench for out_value_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A small UART receiver task decodes tx at mid-bit positions; each scenario
// task compares decoded words and status outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_out_value_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
`ifdef OUT_VALUE_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WORD_CYCLES = 4 * FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] Out_value;
  logic          capture_en;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [2:0]    fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  out_value_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .DATA_W       (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Out_value  (Out_value),
    .capture_en (capture_en),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decodes one 4-byte word. Sampling is on falling edges at offset CPB/2
  // inside each bit; the next start bit is expected exactly one bit after the
  // stop sample, so any idle gap between bytes shows up as a framing error.
  task automatic recv_word(output logic [31:0] w, output logic frame_ok,
                           output logic [3:0] par, output logic timed_out);
    int n;
    w         = '0;
    par       = '0;
    frame_ok  = 1'b1;
    timed_out = 1'b0;
    n         = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      if (b == 0) repeat (CPB / 2) @(negedge clk);
      else        repeat (CPB) @(negedge clk);
      if (tx !== 1'b0) frame_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        w[b*8+i] = tx;
      end
`ifdef OUT_VALUE_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      par[b] = tx;
`endif
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) frame_ok = 1'b0;
    end
  endtask

  task automatic wait_not_busy(output logic timed_out);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    timed_out = (busy !== 1'b0);
  endtask

  task automatic test_reset();
    int tx_lows, busy_highs, cnt_nonzero;
    reset      = 1'b0;
    Out_value  = '0;
    capture_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_tx: got %b expected 1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count);
    end
    reset = 1'b1;
    tx_lows = 0; busy_highs = 0; cnt_nonzero = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_lows++;
      if (busy !== 1'b0) busy_highs++;
      if (fifo_count !== 3'd0) cnt_nonzero++;
    end
    checks++;
    if (tx_lows != 0) begin
      errors++;
      $display("[TB] FAIL idle_tx_low_cycles: got %0d expected 0", tx_lows);
    end
    checks++;
    if (busy_highs != 0) begin
      errors++;
      $display("[TB] FAIL idle_busy_cycles: got %0d expected 0", busy_highs);
    end
    checks++;
    if (cnt_nonzero != 0) begin
      errors++;
      $display("[TB] FAIL idle_count_cycles: got %0d expected 0", cnt_nonzero);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic        ok, to;
    logic [3:0]  par;
    int          t0;
    @(negedge clk);
    Out_value = 32'h1234_5678;
    @(posedge clk); #1;
    checks++;
    if (fifo_count !== 3'd1 || tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_capture_edge: got count=%0d tx=%b busy=%b expected 1/1/1",
               fifo_count, tx, busy);
    end
    @(posedge clk); #1;
    t0 = cyc;
    checks++;
    if (tx !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL single_pop_edge: got tx=%b count=%0d expected 0/0", tx, fifo_count);
    end
    recv_word(w, ok, par, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_rx_timeout: got timeout=%b expected 0", to);
    end
    checks++;
    if (w !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL single_word: got %h expected 12345678", w);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_framing: got %b expected 1", ok);
    end
    wait_not_busy(to);
    checks++;
    if (to !== 1'b0 && (cyc - t0) != WORD_CYCLES) begin
      errors++;
      $display("[TB] FAIL single_busy_drop: timeout, got %0d cycles expected %0d", cyc - t0, WORD_CYCLES);
    end else if ((cyc - t0) != WORD_CYCLES) begin
      errors++;
      $display("[TB] FAIL single_busy_drop: got %0d cycles expected %0d", cyc - t0, WORD_CYCLES);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] got [5];
    logic        fok [5];
    logic        tmo [5];
    logic [3:0]  par;
    logic        to;
    int          lows;
    @(negedge clk);
    Out_value = 32'h1;
    fork
      begin
        for (int v = 2; v <= 6; v++) begin
          @(negedge clk);
          Out_value = DW'(v);
        end
        @(posedge clk); #1;
        checks++;
        if (fifo_count !== 3'd4) begin
          errors++;
          $display("[TB] FAIL ovf_count_full: got %0d expected 4", fifo_count);
        end
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ovf_flag_set: got %b expected 1", overflow);
        end
      end
      begin
        for (int k = 0; k < 5; k++) begin
          recv_word(got[k], fok[k], par, tmo[k]);
        end
      end
    join
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tmo[k] !== 1'b0 || got[k] !== 32'(k + 1) || fok[k] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ovf_word%0d: got %h frame_ok=%b timeout=%b expected %h frame_ok=1",
                 k, got[k], fok[k], tmo[k], 32'(k + 1));
      end
    end
    wait_not_busy(to);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (to !== 1'b0 || lows != 0) begin
      errors++;
      $display("[TB] FAIL ovf_no_extra_word: got busy_timeout=%b tx_low_cycles=%0d expected 0/0", to, lows);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_capture_en();
    logic [31:0] w;
    logic        ok, to;
    logic [3:0]  par;
    int          lows, cnt_nz;
    @(negedge clk);
    capture_en = 1'b0;
    Out_value  = 32'hA;
    lows = 0; cnt_nz = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) Out_value = 32'hB;
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (fifo_count !== 3'd0) cnt_nz++;
    end
    checks++;
    if (lows != 0 || cnt_nz != 0) begin
      errors++;
      $display("[TB] FAIL cap_disabled: got tx_low=%0d count_nonzero=%0d expected 0/0", lows, cnt_nz);
    end
    capture_en = 1'b1;
    recv_word(w, ok, par, to);
    checks++;
    if (to !== 1'b0 || w !== 32'h0000_000B || ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cap_word: got %h frame_ok=%b timeout=%b expected 0000000b frame_ok=1", w, ok, to);
    end
    wait_not_busy(to);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (to !== 1'b0 || lows != 0) begin
      errors++;
      $display("[TB] FAIL cap_single_only: got busy_timeout=%b tx_low_cycles=%0d expected 0/0", to, lows);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    logic        ok, to;
    logic [3:0]  par;
    @(negedge clk);
    Out_value = 32'h5A00_C3A5;
    @(posedge clk);
    @(posedge clk);
    // Lands in data bit 1 of byte 2 (0x00), so tx is low before reset.
    repeat (2 * FRAME_BITS * CPB + CPB + 6) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got tx=%b overflow=%b expected 0/1", tx, overflow);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || fifo_count !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_async: got tx=%b count=%0d overflow=%b busy=%b expected 1/0/0/0",
               tx, fifo_count, overflow, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    recv_word(w, ok, par, to);
    checks++;
    if (to !== 1'b0 || w !== 32'h5A00_C3A5 || ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_resend: got %h frame_ok=%b timeout=%b expected 5a00c3a5 frame_ok=1", w, ok, to);
    end
    wait_not_busy(to);
  endtask

`ifdef OUT_VALUE_TX_PARITY_EN
  task automatic test_parity();
    logic [31:0] w;
    logic        ok, to;
    logic [3:0]  par;
    @(negedge clk);
    Out_value = 32'h0000_0007;
    recv_word(w, ok, par, to);
    checks++;
    if (to !== 1'b0 || w !== 32'h0000_0007 || ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_word: got %h frame_ok=%b timeout=%b expected 00000007 frame_ok=1", w, ok, to);
    end
    checks++;
    if (par !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL parity_bits: got %b expected 0001", par);
    end
    wait_not_busy(to);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_capture_en();
    test_reset_mid_frame();
`ifdef OUT_VALUE_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
